imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream writer for the instruction memory that the fetch stage reads. It receives a length-prefixed program image over a valid/ready byte interface and writes it byte-by-byte into instruction memory starting at `BASE_ADDR`. It holds the pipeline in reset (`Core_Rst`) until the final byte has been committed. It sits beside the fetch stage as the write port of the memory that fetch reads through `PC_F`, and replaces file preloading for on-target programming.

## Interface
- `ADDR_WIDTH`, default 12: instruction memory byte-address width (4 KiB).
- `BASE_ADDR`, default 0: byte address of the first payload byte.
- `clk`  input  1: single clock, rising-edge.
- `rst`  input  1: synchronous, active-high reset.
- `Byte_Valid`  input  1: source presents `Byte_Data`.
- `Byte_Data`  input  8: stream byte.
- `Byte_Ready`  output  1: loader accepts a byte this cycle.
- `Reload`  input  1: single-cycle pulse; restarts loading from the DONE state.
- `Mem_WE`  output  1: instruction memory byte write enable.
- `Mem_Addr`  output  ADDR_WIDTH: write byte address.
- `Mem_WData`  output  8: write data.
- `Core_Rst`  output  1: holds PC register and pipeline in reset while high.
- `Load_Done`  output  1: image fully written.
- `Overflow`  output  1: image extended past the top of memory.
- `Csum_Err`  output  1: checksum mismatch (see Configuration).

## Operation
- Frame format: length low byte, length high byte (16-bit LEN, little-endian), then LEN payload bytes, then an optional checksum byte.
- A transfer occurs on a rising edge when `Byte_Valid && Byte_Ready && !rst`.
- FSM states are LEN_LO, LEN_HI, DATA, CSUM, DONE. Reset enters LEN_LO.
  - LEN_LO -> LEN_HI on transfer.
  - LEN_HI -> DATA on transfer if LEN != 0.
  - LEN_HI with LEN == 0 goes to CSUM (macro on) or DONE (macro off).
  - DATA: each transfer decrements the remaining count. The transfer that brings it to 0 goes to CSUM or DONE.
  - CSUM -> DONE on transfer.
  - DONE -> LEN_LO on `Reload`. `Reload` in any other state is ignored.
- `Byte_Ready` is combinational: 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in DONE.
- Payload byte k (k = 0..LEN-1) targets address `BASE_ADDR + k`, computed with a 17-bit internal offset.
  - If `BASE_ADDR + k < 2**ADDR_WIDTH`, a write is issued.
  - Otherwise the byte is accepted and discarded (no `Mem_WE`), and `Overflow` is set sticky.
  - Addresses never wrap.
- Registered outputs cleared by `Reload`: `Overflow`, `Csum_Err`, `Load_Done`.
- `Reload` sets `Core_Rst` back to 1.

## Timing
- Reset values: `Mem_WE`=0, `Mem_Addr`=0, `Mem_WData`=0, `Core_Rst`=1, `Load_Done`=0, `Overflow`=0, `Csum_Err`=0, state LEN_LO.
- `Byte_Ready` is high in the cycle after the reset edge. Any transfer attempted while `rst` is high is ignored.
- Write latency is 1 cycle. A payload byte accepted at edge N drives `Mem_WE`=1 with its `Mem_Addr`/`Mem_WData` during cycle N→N+1, and the memory captures it at edge N+1.
- `Mem_WE` is a single-cycle pulse per byte. Back-to-back bytes give a continuous `Mem_WE`.
- Throughput is one byte per cycle with no stall cycles.
- Entering DONE at edge N: `Core_Rst` falls to 0 and `Load_Done` rises to 1 at edge N+1, after the last write has landed.
- `Reload` at edge M: state becomes LEN_LO, `Core_Rst`=1 and `Load_Done`=0 at edge M+1, and `Byte_Ready`=1 from cycle M+1.
- `rst` mid-load aborts immediately and returns every output to its reset value. Memory contents are left as written.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The frame carries one trailing byte in CSUM state.
  - At the CSUM transfer, `Csum_Err` ← (byte != XOR of all LEN payload bytes, including discarded ones). XOR of zero bytes is 0x00.
  - `Csum_Err` is valid from the same edge that enters DONE and is held until `Reload` or `rst`.
  - `Core_Rst` still releases regardless of `Csum_Err`.
- Macro undefined: CSUM state is absent, DATA/LEN_HI go straight to DONE, and `Csum_Err` is tied to 0.

## Test plan
- Reset then frame 04 00 13 00 00 00 (macro off) -> four `Mem_WE` pulses at addresses 0..3 with data 13,00,00,00; `Core_Rst` 1→0 and `Load_Done` 0→1 one cycle after the last byte is accepted.
- Same frame with `Byte_Valid` toggling 1,0,1,0 -> same writes in order, one `Mem_WE` per accepted byte, no writes in gap cycles.
- Macro on, payload AA 55, checksum FF -> `Csum_Err`=0. Checksum 00 -> `Csum_Err`=1, `Load_Done`=1, `Core_Rst`=0.
- `BASE_ADDR`=0xFFE, LEN=4, data 01 02 03 04 -> writes only at 0xFFE, 0xFFF; `Overflow`=1; all 4 bytes accepted; `Load_Done`=1.
- LEN=0 (00 00; checksum 00 when macro on) -> no `Mem_WE`; `Load_Done`=1; `Csum_Err`=0.
- `rst` asserted after 2 of 4 payload bytes -> all outputs at reset values next cycle. A following `Reload` in DONE, then a new frame -> `Core_Rst` reasserted and new data written from `BASE_ADDR`.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: writes a length-prefixed byte stream to memory from BASE_ADDR
// and holds the core in reset until the image is in. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Byte_Valid,
  input  logic [7:0]            Byte_Data,
  output logic                  Byte_Ready,
  input  logic                  Reload,
  output logic                  Mem_WE,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [7:0]            Mem_WData,
  output logic                  Core_Rst,
  output logic                  Load_Done,
  output logic                  Overflow,
  output logic                  Csum_Err
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  localparam logic [17:0] MEM_SIZE = 18'd1 << ADDR_WIDTH;

  state_t      state;
  state_t      state_next;
  logic [7:0]  len_lo;
  logic [15:0] remaining;
  logic [16:0] offset;
  logic [17:0] abs_addr;
  logic [15:0] frame_len;
  logic        in_range;
  logic        xfer;

  assign Byte_Ready = (state != DONE);
  assign xfer       = Byte_Valid && Byte_Ready;
  assign frame_len  = {Byte_Data, len_lo};
  // Wide enough that BASE_ADDR + offset can never wrap; bytes past the top are dropped.
  assign abs_addr   = {1'b0, offset} + 18'(BASE_ADDR);
  assign in_range   = (abs_addr < MEM_SIZE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LEN_LO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LEN_LO: begin
        if (xfer) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (xfer) state_next = (frame_len != 16'd0) ? DATA : AFTER_DATA;
      end
      DATA: begin
        if (xfer && (remaining == 16'd1)) state_next = AFTER_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) state_next = DONE;
      end
`endif
      DONE: begin
        if (Reload) state_next = LEN_LO;
      end
      default: state_next = LEN_LO;
    endcase
  end

  // Core release and Load_Done follow DONE one cycle late, so the final write has landed first.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo    <= '0;
      remaining <= '0;
      offset    <= '0;
      Mem_WE    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      Core_Rst  <= 1'b1;
      Load_Done <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      Mem_WE <= 1'b0;
      case (state)
        LEN_LO: begin
          if (xfer) len_lo <= Byte_Data;
        end
        LEN_HI: begin
          if (xfer) begin
            remaining <= frame_len;
            offset    <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            remaining <= remaining - 16'd1;
            offset    <= offset + 17'd1;
            if (in_range) begin
              Mem_WE    <= 1'b1;
              Mem_Addr  <= abs_addr[ADDR_WIDTH-1:0];
              Mem_WData <= Byte_Data;
            end else begin
              Overflow <= 1'b1;
            end
          end
        end
        DONE: begin
          if (Reload) begin
            Core_Rst  <= 1'b1;
            Load_Done <= 1'b0;
            Overflow  <= 1'b0;
          end else begin
            Core_Rst  <= 1'b0;
            Load_Done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;

  // Running XOR includes out-of-range payload bytes, since the sender checksums the whole image.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_acc <= '0;
      Csum_Err <= 1'b0;
    end else begin
      if ((state == LEN_HI) && xfer) begin
        csum_acc <= '0;
      end else if ((state == DATA) && xfer) begin
        csum_acc <= csum_acc ^ Byte_Data;
      end
      if ((state == CSUM) && xfer) begin
        Csum_Err <= (Byte_Data != csum_acc);
      end else if ((state == DONE) && Reload) begin
        Csum_Err <= 1'b0;
      end
    end
  end
`else
  assign Csum_Err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0xFFE) share one byte stream and
// are compared against a frame-level model of the writes, overflow and checksum result.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW    = 12;
  localparam int BASE1 = 'hFFE;

  logic          clk;
  logic          rst;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          reload;

  logic          ready0, we0, core_rst0, done0, ovf0, cerr0;
  logic [AW-1:0] addr0;
  logic [7:0]    wdata0;
  logic          ready1, we1, core_rst1, done1, ovf1, cerr1;
  logic [AW-1:0] addr1;
  logic [7:0]    wdata1;

  int total = 0;
  int bad   = 0;

  logic [19:0] got0[$];
  logic [19:0] got1[$];
  logic [19:0] exp0[$];
  logic [19:0] exp1[$];
  logic [7:0]  payload[$];
  logic [7:0]  stream[$];
  logic        exp_ovf0, exp_ovf1, exp_cerr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .Byte_Valid(byte_valid), .Byte_Data(byte_data),
    .Byte_Ready(ready0), .Reload(reload), .Mem_WE(we0), .Mem_Addr(addr0),
    .Mem_WData(wdata0), .Core_Rst(core_rst0), .Load_Done(done0),
    .Overflow(ovf0), .Csum_Err(cerr0)
  );

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst(rst), .Byte_Valid(byte_valid), .Byte_Data(byte_data),
    .Byte_Ready(ready1), .Reload(reload), .Mem_WE(we1), .Mem_Addr(addr1),
    .Mem_WData(wdata1), .Core_Rst(core_rst1), .Load_Done(done1),
    .Overflow(ovf1), .Csum_Err(cerr1)
  );

  // Every write-enable cycle is logged as {addr, data}
  always @(negedge clk) begin
    if (we0) got0.push_back({addr0, wdata0});
    if (we1) got1.push_back({addr1, wdata1});
  end

  // Frame model: builds the byte stream and the writes each base address should see
  task automatic build_frame(input logic have_chk, input logic [7:0] chk_in);
    logic [7:0] x;
    int a;
    x = 8'h00;
    stream.delete(); exp0.delete(); exp1.delete();
    exp_ovf0 = 1'b0; exp_ovf1 = 1'b0; exp_cerr = 1'b0;
    stream.push_back(8'(payload.size()));
    stream.push_back(8'(payload.size() >> 8));
    foreach (payload[k]) begin
      stream.push_back(payload[k]);
      x = x ^ payload[k];
      a = k;
      if (a < (1 << AW)) exp0.push_back({12'(a), payload[k]}); else exp_ovf0 = 1'b1;
      a = BASE1 + k;
      if (a < (1 << AW)) exp1.push_back({12'(a), payload[k]}); else exp_ovf1 = 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] chk;
      chk = have_chk ? chk_in : x;
      stream.push_back(chk);
      exp_cerr = (chk != x);
    end
`endif
  endtask

  // Drives the stream from a negedge; returns at the negedge after the last transfer
  task automatic send_bytes(input int gap_mode, input int reload_at);
    foreach (stream[i]) begin
      int gap;
      gap = 0;
      if (gap_mode == 1 && i > 0) gap = 1;
      if (gap_mode == 2) gap = int'($urandom_range(2, 0));
      byte_valid = 1'b0;
      reload = 1'b0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data = stream[i];
      reload = (i == reload_at);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    reload = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h07;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b0;
    total++;
    if ({ready0, we0, addr0, wdata0, core_rst0, done0, ovf0, cerr0} !== {1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_dut0 got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b ovf=%b cerr=%b required 1 0 000 00 1 0 0 0",
               ready0, we0, addr0, wdata0, core_rst0, done0, ovf0, cerr0);
    end
    total++;
    if ({ready1, we1, core_rst1, done1, ovf1} !== 5'b10100) begin
      bad++;
      $display("[TB] FAIL reset_dut1 got rdy=%b we=%b crst=%b done=%b ovf=%b required 1 0 1 0 0",
               ready1, we1, core_rst1, done1, ovf1);
    end
  endtask

  task automatic test_basic();
    int nerr;
    payload = '{8'h13, 8'h00, 8'h00, 8'h00};
    build_frame(1'b0, 8'h00);
    got0.delete(); got1.delete();
    send_bytes(0, -1);
    total++;
    if (done0 !== 1'b0 || core_rst0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_early_release got done=%b crst=%b required done=0 crst=1", done0, core_rst0);
    end
    @(negedge clk);
    total++;
    if (done0 !== 1'b1 || core_rst0 !== 1'b0 || ready0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_release got done=%b crst=%b rdy=%b required done=1 crst=0 rdy=0", done0, core_rst0, ready0);
    end
    nerr = 0;
    if (got0.size() != exp0.size()) nerr++;
    foreach (exp0[i]) if (i < got0.size() && got0[i] !== exp0[i]) nerr++;
    total++;
    if (nerr != 0) begin
      bad++;
      $display("[TB] FAIL basic_writes0 got %0d writes (%0d differ) required %0d", got0.size(), nerr, exp0.size());
    end
    nerr = 0;
    if (got1.size() != exp1.size()) nerr++;
    foreach (exp1[i]) if (i < got1.size() && got1[i] !== exp1[i]) nerr++;
    total++;
    if (nerr != 0 || ovf1 !== exp_ovf1) begin
      bad++;
      $display("[TB] FAIL basic_writes1 got %0d writes (%0d differ) ovf=%b required %0d writes ovf=%b",
               got1.size(), nerr, ovf1, exp1.size(), exp_ovf1);
    end
  endtask

  task automatic test_valid_gaps();
    int nerr;
    do_reload();
    total++;
    if (done0 !== 1'b0 || core_rst0 !== 1'b1 || ready0 !== 1'b1 || ovf1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reload_state got done=%b crst=%b rdy=%b ovf1=%b required 0 1 1 0", done0, core_rst0, ready0, ovf1);
    end
    payload = '{8'h13, 8'h00, 8'h00, 8'h00};
    build_frame(1'b0, 8'h00);
    got0.delete(); got1.delete();
    send_bytes(1, -1);
    @(negedge clk);
    nerr = 0;
    if (got0.size() != exp0.size()) nerr++;
    foreach (exp0[i]) if (i < got0.size() && got0[i] !== exp0[i]) nerr++;
    total++;
    if (nerr != 0 || done0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL gaps_writes0 got %0d writes (%0d differ) done=%b required %0d writes done=1",
               got0.size(), nerr, done0, exp0.size());
    end
  endtask

  task automatic test_checksum();
    do_reload();
    payload = '{8'hAA, 8'h55};
`ifdef IMEM_LOADER_CHECKSUM_EN
    build_frame(1'b1, 8'hFF);
    send_bytes(0, -1);
    total++;
    if (cerr0 !== exp_cerr) begin
      bad++;
      $display("[TB] FAIL csum_good got cerr=%b required %b", cerr0, exp_cerr);
    end
    @(negedge clk);
    do_reload();
    build_frame(1'b1, 8'h00);
    send_bytes(0, -1);
    total++;
    if (cerr0 !== exp_cerr) begin
      bad++;
      $display("[TB] FAIL csum_bad got cerr=%b required %b", cerr0, exp_cerr);
    end
    @(negedge clk);
    total++;
    if (cerr0 !== 1'b1 || done0 !== 1'b1 || core_rst0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL csum_bad_release got cerr=%b done=%b crst=%b required 1 1 0", cerr0, done0, core_rst0);
    end
`else
    build_frame(1'b1, 8'h00);
    send_bytes(0, -1);
    @(negedge clk);
    total++;
    if (cerr0 !== 1'b0 || done0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL csum_off got cerr=%b done=%b required cerr=0 done=1", cerr0, done0);
    end
`endif
  endtask

  task automatic test_zero_len();
    do_reload();
    total++;
    if (cerr0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reload_cerr got cerr=%b required 0", cerr0);
    end
    payload.delete();
    build_frame(1'b1, 8'h00);
    got0.delete(); got1.delete();
    send_bytes(0, -1);
    @(negedge clk);
    total++;
    if (got0.size() != 0 || got1.size() != 0 || done0 !== 1'b1 || cerr0 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_len got writes=%0d/%0d done=%b cerr=%b ovf1=%b required 0/0 1 0 0",
               got0.size(), got1.size(), done0, cerr0, ovf1);
    end
  endtask

  task automatic test_overflow();
    int nerr;
    do_reload();
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    build_frame(1'b0, 8'h00);
    got0.delete(); got1.delete();
    send_bytes(0, -1);
    @(negedge clk);
    nerr = 0;
    if (got1.size() != 2) nerr++;
    if (got1.size() > 0 && got1[0] !== {12'hFFE, 8'h01}) nerr++;
    if (got1.size() > 1 && got1[1] !== {12'hFFF, 8'h02}) nerr++;
    total++;
    if (nerr != 0) begin
      bad++;
      $display("[TB] FAIL overflow_writes got %0d writes (%0d wrong) required 2 at FFE,FFF", got1.size(), nerr);
    end
    total++;
    if (ovf1 !== 1'b1 || done1 !== 1'b1 || ovf0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overflow_flags got ovf1=%b done1=%b ovf0=%b required 1 1 0", ovf1, done1, ovf0);
    end
  endtask

  task automatic test_abort();
    int nerr;
    do_reload();
    payload = '{8'h5A, 8'hC3, 8'h11, 8'h22};
    build_frame(1'b0, 8'h00);
    while (stream.size() > 4) void'(stream.pop_back());
    send_bytes(0, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ready0, we0, addr0, wdata0, core_rst0, done0, ovf0, cerr0} !== {1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL abort_reset got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b ovf=%b cerr=%b required 1 0 000 00 1 0 0 0",
               ready0, we0, addr0, wdata0, core_rst0, done0, ovf0, cerr0);
    end
    do_reload();
    payload = '{8'h99, 8'h88, 8'h77};
    build_frame(1'b0, 8'h00);
    got0.delete(); got1.delete();
    send_bytes(0, -1);
    @(negedge clk);
    nerr = 0;
    if (got0.size() != exp0.size()) nerr++;
    foreach (exp0[i]) if (i < got0.size() && got0[i] !== exp0[i]) nerr++;
    total++;
    if (nerr != 0 || done0 !== 1'b1 || core_rst0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_refill got %0d writes (%0d differ) done=%b crst=%b required %0d writes 1 0",
               got0.size(), nerr, done0, core_rst0, exp0.size());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int nerr0, nerr1, n;
      do_reload();
      total++;
      if (done0 !== 1'b0 || core_rst0 !== 1'b1 || ovf1 !== 1'b0 || cerr0 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rand%0d_reload got done=%b crst=%b ovf1=%b cerr=%b required 0 1 0 0", f, done0, core_rst0, ovf1, cerr0);
      end
      payload.delete();
      n = int'($urandom_range(9, 0));
      repeat (n) payload.push_back(8'($urandom));
      build_frame(1'($urandom), 8'($urandom));
      got0.delete(); got1.delete();
      send_bytes(2, int'($urandom_range(n + 2, 1)));
      total++;
      if (cerr0 !== exp_cerr || done0 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rand%0d_end got cerr=%b done=%b required cerr=%b done=0", f, cerr0, done0, exp_cerr);
      end
      @(negedge clk);
      nerr0 = 0;
      if (got0.size() != exp0.size()) nerr0++;
      foreach (exp0[i]) if (i < got0.size() && got0[i] !== exp0[i]) nerr0++;
      nerr1 = 0;
      if (got1.size() != exp1.size()) nerr1++;
      foreach (exp1[i]) if (i < got1.size() && got1[i] !== exp1[i]) nerr1++;
      total++;
      if (nerr0 != 0 || nerr1 != 0 || ovf0 !== exp_ovf0 || ovf1 !== exp_ovf1 || done1 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL rand%0d_frame got writes=%0d/%0d differ=%0d/%0d ovf=%b/%b done1=%b required writes=%0d/%0d ovf=%b/%b done1=1",
                 f, got0.size(), got1.size(), nerr0, nerr1, ovf0, ovf1, done1, exp0.size(), exp1.size(), exp_ovf0, exp_ovf1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    reload = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_valid_gaps();
    test_checksum();
    test_zero_len();
    test_overflow();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
